// File: rtl/fir_stim_gen_if.sv
// rtl/fir_stim_gen_if.sv - command and sample bundle between a test controller and fir_stim_gen
interface fir_stim_gen_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16
);
   logic                     start;
   logic                     abort;
   logic [2:0]               mode;
   logic signed [DATA_W-1:0] amplitude;
   logic [LEN_W-1:0]         length;
   logic [LEN_W-1:0]         half_period;
   logic signed [DATA_W-1:0] x_out;
   logic                     x_valid;
   logic                     busy;
   logic                     done;

   modport master (
      output start, abort, mode, amplitude, length, half_period,
      input  x_out, x_valid, busy, done
   );

   modport slave (
      input  start, abort, mode, amplitude, length, half_period,
      output x_out, x_valid, busy, done
   );
endinterface

// File: rtl/fir_stim_gen.sv
// rtl/fir_stim_gen.sv - impulse/step/square/ramp sample source feeding fir_filter x_in
// Mode 4 emits a 16-bit LFSR only when FIR_STIM_NOISE_EN is defined; otherwise it emits zeros.
module fir_stim_gen #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16
`ifdef FIR_STIM_NOISE_EN
   ,parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
   input logic       clk,
   input logic       reset,
   fir_stim_gen_if.slave bus
);
   localparam int ACC_W = DATA_W + LEN_W + 1;
   localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  A_MAX = {{(LEN_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  A_MIN = {{(LEN_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   localparam logic [2:0] M_IMPULSE = 3'd0;
   localparam logic [2:0] M_STEP    = 3'd1;
   localparam logic [2:0] M_SQUARE  = 3'd2;
   localparam logic [2:0] M_RAMP    = 3'd3;
   localparam logic [2:0] M_NOISE   = 3'd4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   logic [2:0]               mode_q;
   logic signed [DATA_W-1:0] amp_q;
   logic signed [DATA_W-1:0] neg_q;
   logic [LEN_W-1:0]         last_q;
   logic [LEN_W-1:0]         half_q;
   logic [LEN_W-1:0]         cnt;
   logic [LEN_W-1:0]         phase;
   logic                     sgn;
   logic signed [ACC_W-1:0]  acc;

   logic [LEN_W-1:0]         phase_nx;
   logic                     sgn_nx;
   logic signed [ACC_W-1:0]  acc_nx;
   logic signed [DATA_W-1:0] sample_nx;
   logic signed [DATA_W-1:0] first;

`ifdef FIR_STIM_NOISE_EN
   logic [15:0] lfsr;
   logic [15:0] lfsr_nx;
   assign lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > A_MAX)
         return D_MAX;
      else if (v < A_MIN)
         return D_MIN;
      else
         return v[DATA_W-1:0];
   endfunction

   // Next-sample terms for index cnt+1; the ramp accumulates n*A instead of multiplying.
   always_comb begin
      phase_nx = phase + 1'b1;
      sgn_nx   = sgn;
      if (phase_nx == half_q) begin
         phase_nx = '0;
         sgn_nx   = ~sgn;
      end
      acc_nx = acc + {{(LEN_W+1){amp_q[DATA_W-1]}}, amp_q};
      sample_nx = '0;
      case (mode_q)
         M_STEP:   sample_nx = amp_q;
         M_SQUARE: sample_nx = sgn_nx ? neg_q : amp_q;
         M_RAMP:   sample_nx = sat(acc_nx);
`ifdef FIR_STIM_NOISE_EN
         M_NOISE:  sample_nx = DATA_W'(lfsr_nx);
`endif
         default:  sample_nx = '0;
      endcase
   end

   always_comb begin
      first = '0;
      case (bus.mode)
         M_IMPULSE, M_STEP, M_SQUARE: first = bus.amplitude;
`ifdef FIR_STIM_NOISE_EN
         M_NOISE: first = DATA_W'(LFSR_SEED);
`endif
         default: first = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bus.x_out   <= '0;
         bus.x_valid <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         mode_q      <= '0;
         amp_q       <= '0;
         neg_q       <= '0;
         last_q      <= '0;
         half_q      <= '0;
         cnt         <= '0;
         phase       <= '0;
         sgn         <= 1'b0;
         acc         <= '0;
`ifdef FIR_STIM_NOISE_EN
         lfsr        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  if (bus.length == '0) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     state       <= RUN;
                     bus.busy    <= 1'b1;
                     bus.x_valid <= 1'b1;
                     bus.x_out   <= first;
                     mode_q      <= bus.mode;
                     amp_q       <= bus.amplitude;
                     neg_q       <= (bus.amplitude == D_MIN) ? D_MAX : -bus.amplitude;
                     last_q      <= bus.length - 1'b1;
                     half_q      <= (bus.half_period == '0) ? LEN_W'(1) : bus.half_period;
                     cnt         <= '0;
                     phase       <= '0;
                     sgn         <= 1'b0;
                     acc         <= '0;
`ifdef FIR_STIM_NOISE_EN
                     lfsr        <= LFSR_SEED;
`endif
                  end
               end
            end
            RUN: begin
               if (bus.abort || cnt == last_q) begin
                  state       <= bus.abort ? IDLE : DONE;
                  bus.done    <= !bus.abort;
                  bus.busy    <= 1'b0;
                  bus.x_valid <= 1'b0;
                  bus.x_out   <= '0;
               end else begin
                  cnt       <= cnt + 1'b1;
                  phase     <= phase_nx;
                  sgn       <= sgn_nx;
                  acc       <= acc_nx;
                  bus.x_out <= sample_nx;
`ifdef FIR_STIM_NOISE_EN
                  lfsr      <= lfsr_nx;
`endif
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
